// File: rtl/minimac_pkg.sv
// Shared encodings for the minimac receive path: main FSM states,
// receive-slot states and the byte-count width.
package minimac_pkg;

  localparam int CNT_W = 11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RECV    = 3'd1,
    ST_WRITE   = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DISCARD = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    SLOT_FREE  = 2'd0,
    SLOT_ARMED = 2'd1,
    SLOT_BUSY  = 2'd2,
    SLOT_DONE  = 2'd3
  } slot_state_t;

endpackage

// File: rtl/minimac_rxslot.sv
// One software-armed receive slot: state, buffer base and committed length.
// Receiver actions (take/rel/commit) outrank software arm/clear.
module minimac_rxslot
  import minimac_pkg::*;
#(
  parameter int ADDR_WIDTH = 30
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic [ADDR_WIDTH-1:0] base_in,
  input  logic                  clear,
  input  logic                  take,
  input  logic                  rel,
  input  logic                  commit,
  input  logic [CNT_W-1:0]      count_in,
  output logic [1:0]            state,
  output logic [ADDR_WIDTH-1:0] base,
  output logic [CNT_W-1:0]      count
);

  slot_state_t st;

  assign state = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= SLOT_FREE;
      base  <= '0;
      count <= '0;
    end else begin
      case (st)
        SLOT_FREE: begin
          if (arm) begin
            st   <= SLOT_ARMED;
            base <= base_in;
          end
        end
        SLOT_ARMED: begin
          if (take) st <= SLOT_BUSY;
          else if (arm) base <= base_in;
        end
        SLOT_BUSY: begin
          if (commit) begin
            st    <= SLOT_DONE;
            count <= count_in;
          end else if (rel) begin
            st <= SLOT_ARMED;
          end
        end
        default: begin
          if (clear) st <= SLOT_FREE;
        end
      endcase
    end
  end

endmodule

// File: rtl/minimac_rxctl.sv
// Receive controller: drains the RX FIFO, packs bytes big-endian into words,
// writes them to the selected slot buffer and commits or drops each frame.
module minimac_rxctl
  import minimac_pkg::*;
#(
  parameter int MAX_BYTES  = 1530,
  parameter int ADDR_WIDTH = 30
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_ack,
  input  logic                  fifo_eof,
  input  logic [7:0]            fifo_data,
  input  logic                  slot0_arm,
  input  logic                  slot1_arm,
  input  logic [ADDR_WIDTH-1:0] slot0_base,
  input  logic [ADDR_WIDTH-1:0] slot1_base,
  input  logic                  slot0_clear,
  input  logic                  slot1_clear,
  output logic [1:0]            slot0_state,
  output logic [1:0]            slot1_state,
  output logic [CNT_W-1:0]      slot0_count,
  output logic [CNT_W-1:0]      slot1_count,
  output logic [ADDR_WIDTH-1:0] m_adr,
  output logic [31:0]           m_dat,
  output logic [3:0]            m_sel,
  output logic                  m_stb,
  input  logic                  m_ack,
  output logic                  rx_irq,
  output logic [15:0]           drop_count
);

  rx_state_t             state;
  logic                  cur;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-3:0]      widx;
  logic [31:0]           shreg;
  logic [31:0]           word_next;
  logic [3:0]            flush_sel;
  logic [1:0]            lane;
  logic [ADDR_WIDTH-1:0] base0, base1, base_cur;
  logic                  is_data, is_eof, good_eof, full;
  logic                  pop, take0, take1, rel, cmt, drop;

  assign lane     = count[1:0];
  assign base_cur = cur ? base1 : base0;
  // FWFT head must be popped in the cycle it is consumed, so the ack is decoded, not registered.
  assign fifo_ack = pop && sys_rst_n;

  always_comb begin
    is_data  = !fifo_empty && !fifo_eof;
    is_eof   = !fifo_empty && fifo_eof;
    good_eof = is_eof && !fifo_data[0] && (count != '0);
    full     = (count == CNT_W'(MAX_BYTES));
    pop   = 1'b0;
    take0 = 1'b0;
    take1 = 1'b0;
    rel   = 1'b0;
    cmt   = 1'b0;
    drop  = 1'b0;
    case (state)
      ST_IDLE: begin
        pop  = is_eof;
        drop = is_eof;
        if (is_data) begin
          take0 = (slot0_state == SLOT_ARMED);
          take1 = (slot1_state == SLOT_ARMED) && (slot0_state != SLOT_ARMED);
        end
      end
      ST_RECV: begin
        pop  = !fifo_empty;
        rel  = (is_data && full) || (is_eof && !good_eof);
        drop = is_eof && !good_eof;
        cmt  = good_eof && (lane == 2'd0);
      end
      ST_FLUSH:   cmt = m_stb && m_ack;
      ST_DISCARD: begin
        pop  = !fifo_empty;
        drop = is_eof;
      end
      default: ;
    endcase

    case (lane)
      2'd0:    word_next = {fifo_data, 24'h0};
      2'd1:    word_next = {shreg[31:24], fifo_data, 16'h0};
      2'd2:    word_next = {shreg[31:16], fifo_data, 8'h0};
      default: word_next = {shreg[31:8], fifo_data};
    endcase

    case (lane)
      2'd1:    flush_sel = 4'b1000;
      2'd2:    flush_sel = 4'b1100;
      default: flush_sel = 4'b1110;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      cur        <= 1'b0;
      count      <= '0;
      widx       <= '0;
      shreg      <= '0;
      m_stb      <= 1'b0;
      m_adr      <= '0;
      m_dat      <= '0;
      m_sel      <= '0;
      rx_irq     <= 1'b0;
      drop_count <= '0;
    end else begin
      rx_irq <= 1'b0;
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      case (state)
        ST_IDLE: begin
          if (take0 || take1) begin
            cur   <= take1;
            count <= '0;
            widx  <= '0;
            state <= ST_RECV;
          end else if (is_data) begin
            state <= ST_DISCARD;
          end
        end
        ST_RECV: begin
          if (is_data) begin
            if (full) begin
              state <= ST_DISCARD;
            end else begin
              count <= count + 1'b1;
              shreg <= word_next;
              if (lane == 2'd3) begin
                state <= ST_WRITE;
                m_stb <= 1'b1;
                m_adr <= base_cur + ADDR_WIDTH'(widx);
                m_dat <= word_next;
                m_sel <= 4'b1111;
              end
            end
          end else if (is_eof) begin
            if (!good_eof) begin
              state <= ST_IDLE;
            end else if (lane == 2'd0) begin
              rx_irq <= 1'b1;
              state  <= ST_IDLE;
            end else begin
              state <= ST_FLUSH;
              m_stb <= 1'b1;
              m_adr <= base_cur + ADDR_WIDTH'(widx);
              m_dat <= shreg;
              m_sel <= flush_sel;
            end
          end
        end
        ST_WRITE: begin
          if (m_ack) begin
            m_stb <= 1'b0;
            widx  <= widx + 1'b1;
            state <= ST_RECV;
          end
        end
        ST_FLUSH: begin
          if (m_ack) begin
            m_stb  <= 1'b0;
            widx   <= widx + 1'b1;
            rx_irq <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: begin
          if (is_eof) state <= ST_IDLE;
        end
      endcase
    end
  end

  minimac_rxslot #(.ADDR_WIDTH(ADDR_WIDTH)) u_slot0 (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .arm      (slot0_arm),
    .base_in  (slot0_base),
    .clear    (slot0_clear),
    .take     (take0),
    .rel      (rel && !cur),
    .commit   (cmt && !cur),
    .count_in (count),
    .state    (slot0_state),
    .base     (base0),
    .count    (slot0_count)
  );

  minimac_rxslot #(.ADDR_WIDTH(ADDR_WIDTH)) u_slot1 (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .arm      (slot1_arm),
    .base_in  (slot1_base),
    .clear    (slot1_clear),
    .take     (take1),
    .rel      (rel && cur),
    .commit   (cmt && cur),
    .count_in (count),
    .state    (slot1_state),
    .base     (base1),
    .count    (slot1_count)
  );

endmodule

// File: tb/tb_minimac_rxctl.sv
// Directed bench for minimac_rxctl: FIFO and memory-port models plus one task per scenario.
module tb_minimac_rxctl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_ack;
  logic        fifo_eof = 1'b0;
  logic [7:0]  fifo_data = 8'h0;
  logic        slot0_arm = 1'b0, slot1_arm = 1'b0;
  logic [29:0] slot0_base = '0, slot1_base = '0;
  logic        slot0_clear = 1'b0, slot1_clear = 1'b0;
  logic [1:0]  slot0_state, slot1_state;
  logic [10:0] slot0_count, slot1_count;
  logic [29:0] m_adr;
  logic [31:0] m_dat;
  logic [3:0]  m_sel;
  logic        m_stb;
  logic        m_ack = 1'b0;
  logic        rx_irq;
  logic [15:0] drop_count;

  int total = 0;
  int bad = 0;
  int pops = 0;
  int irq_cnt = 0;
  int ack_delay = 0;
  int wcnt = 0;
  logic [8:0]  q[$];
  logic [65:0] wlog[$];

  minimac_rxctl dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .fifo_empty(fifo_empty), .fifo_ack(fifo_ack), .fifo_eof(fifo_eof), .fifo_data(fifo_data),
    .slot0_arm(slot0_arm), .slot1_arm(slot1_arm), .slot0_base(slot0_base), .slot1_base(slot1_base),
    .slot0_clear(slot0_clear), .slot1_clear(slot1_clear),
    .slot0_state(slot0_state), .slot1_state(slot1_state),
    .slot0_count(slot0_count), .slot1_count(slot1_count),
    .m_adr(m_adr), .m_dat(m_dat), .m_sel(m_sel), .m_stb(m_stb), .m_ack(m_ack),
    .rx_irq(rx_irq), .drop_count(drop_count)
  );

  always #5 sys_clk = ~sys_clk;

  // FWFT FIFO model, write-port logger and irq counter
  always @(posedge sys_clk) begin
    if (fifo_ack && q.size() > 0) begin
      void'(q.pop_front());
      pops++;
    end
    if (m_stb && m_ack) wlog.push_back({m_adr, m_dat, m_sel});
    if (rx_irq) irq_cnt++;
    fifo_empty <= (q.size() == 0);
    fifo_eof   <= (q.size() > 0) ? q[0][8] : 1'b0;
    fifo_data  <= (q.size() > 0) ? q[0][7:0] : 8'h0;
  end

  always @(negedge sys_clk) begin
    if (m_stb) begin
      m_ack = (wcnt == ack_delay);
      wcnt++;
    end else begin
      m_ack = 1'b0;
      wcnt = 0;
    end
  end

  task automatic do_reset();
    sys_rst_n = 1'b0;
    q.delete();
    ack_delay = 0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic arm(input int slot, input logic [29:0] base);
    @(negedge sys_clk);
    if (slot == 0) begin slot0_arm = 1'b1; slot0_base = base; end
    else begin slot1_arm = 1'b1; slot1_base = base; end
    @(negedge sys_clk);
    slot0_arm = 1'b0;
    slot1_arm = 1'b0;
  endtask

  task automatic push_frame(input int n, input int start, input logic err);
    for (int i = 0; i < n; i++) q.push_back({1'b0, 8'((start + i) & 255)});
    q.push_back({1'b1, 7'h0, err});
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 5000) begin
      @(negedge sys_clk);
      n++;
    end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL drain: entries left %0d want 0", q.size()); end
    repeat (8) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({slot0_state, slot1_state, slot0_count, slot1_count} !== 26'h0) begin
      bad++; $display("FAIL reset_slots: got %h want 0", {slot0_state, slot1_state, slot0_count, slot1_count});
    end
    total++;
    if ({m_stb, m_adr, m_dat, m_sel} !== 67'h0) begin
      bad++; $display("FAIL reset_mem: got %h want 0", {m_stb, m_adr, m_dat, m_sel});
    end
    total++;
    if ({fifo_ack, rx_irq, drop_count} !== 18'h0) begin
      bad++; $display("FAIL reset_misc: got %h want 0", {fifo_ack, rx_irq, drop_count});
    end
  endtask

  task automatic test_basic();
    int w0, i0;
    do_reset();
    w0 = wlog.size(); i0 = irq_cnt;
    arm(0, 30'h100);
    push_frame(6, 1, 1'b0);
    drain();
    total++;
    if (wlog.size() - w0 !== 2) begin bad++; $display("FAIL basic_nwrites: got %0d want 2", wlog.size() - w0); end
    total++;
    if (wlog[w0] !== {30'h100, 32'h01020304, 4'hF}) begin
      bad++; $display("FAIL basic_w0: got %h want %h", wlog[w0], {30'h100, 32'h01020304, 4'hF});
    end
    total++;
    if (wlog[w0+1] !== {30'h101, 32'h05060000, 4'hC}) begin
      bad++; $display("FAIL basic_w1: got %h want %h", wlog[w0+1], {30'h101, 32'h05060000, 4'hC});
    end
    total++;
    if (slot0_state !== 2'd3 || slot0_count !== 11'd6) begin
      bad++; $display("FAIL basic_slot: got state %0d count %0d want 3 6", slot0_state, slot0_count);
    end
    total++;
    if (irq_cnt - i0 !== 1) begin bad++; $display("FAIL basic_irq: got %0d want 1", irq_cnt - i0); end
    // DONE slot: arm alone is ignored, arm with clear returns it to FREE
    arm(0, 30'h3FF);
    total++;
    if (slot0_state !== 2'd3) begin bad++; $display("FAIL arm_on_done: got %0d want 3", slot0_state); end
    @(negedge sys_clk);
    slot0_arm = 1'b1; slot0_clear = 1'b1; slot0_base = 30'h3FF;
    @(negedge sys_clk);
    slot0_arm = 1'b0; slot0_clear = 1'b0;
    total++;
    if (slot0_state !== 2'd0) begin bad++; $display("FAIL clear_wins: got %0d want 0", slot0_state); end
    arm(0, 30'h500);
    push_frame(1, 8'h7E, 1'b0);
    drain();
    total++;
    if (wlog[wlog.size()-1] !== {30'h500, 32'h7E000000, 4'h8} || slot0_count !== 11'd1) begin
      bad++; $display("FAIL one_byte: got %h cnt %0d want %h cnt 1", wlog[wlog.size()-1], slot0_count,
                      {30'h500, 32'h7E000000, 4'h8});
    end
  endtask

  task automatic test_back_to_back();
    int w0, i0;
    do_reset();
    w0 = wlog.size(); i0 = irq_cnt;
    arm(0, 30'h200);
    arm(1, 30'h300);
    push_frame(4, 8'hAA, 1'b0);
    push_frame(4, 8'h11, 1'b0);
    drain();
    total++;
    if (wlog.size() - w0 !== 2) begin bad++; $display("FAIL b2b_nwrites: got %0d want 2", wlog.size() - w0); end
    total++;
    if (wlog[w0] !== {30'h200, 32'hAAABACAD, 4'hF} || wlog[w0+1] !== {30'h300, 32'h11121314, 4'hF}) begin
      bad++; $display("FAIL b2b_data: got %h %h want %h %h", wlog[w0], wlog[w0+1],
                      {30'h200, 32'hAAABACAD, 4'hF}, {30'h300, 32'h11121314, 4'hF});
    end
    total++;
    if ({slot0_state, slot1_state, slot0_count, slot1_count} !== {2'd3, 2'd3, 11'd4, 11'd4}) begin
      bad++; $display("FAIL b2b_slots: got %0d %0d %0d %0d want 3 3 4 4", slot0_state, slot1_state,
                      slot0_count, slot1_count);
    end
    total++;
    if (irq_cnt - i0 !== 2) begin bad++; $display("FAIL b2b_irq: got %0d want 2", irq_cnt - i0); end
  endtask

  task automatic test_no_slot();
    int w0, p0;
    do_reset();
    w0 = wlog.size(); p0 = pops;
    push_frame(10, 0, 1'b0);
    drain();
    total++;
    if (pops - p0 !== 11) begin bad++; $display("FAIL noslot_pops: got %0d want 11", pops - p0); end
    total++;
    if (drop_count !== 16'd1 || wlog.size() != w0) begin
      bad++; $display("FAIL noslot_drop: got drop %0d writes %0d want 1 0", drop_count, wlog.size() - w0);
    end
  endtask

  task automatic test_error();
    int w0, i0;
    do_reset();
    w0 = wlog.size(); i0 = irq_cnt;
    arm(0, 30'h40);
    push_frame(5, 1, 1'b1);
    drain();
    total++;
    if (slot0_state !== 2'd1 || drop_count !== 16'd1 || irq_cnt != i0) begin
      bad++; $display("FAIL err_frame: got state %0d drop %0d irq %0d want 1 1 0", slot0_state, drop_count, irq_cnt - i0);
    end
    push_frame(4, 8'hA1, 1'b0);
    drain();
    total++;
    if (wlog[wlog.size()-1] !== {30'h40, 32'hA1A2A3A4, 4'hF} || slot0_state !== 2'd3) begin
      bad++; $display("FAIL err_next: got %h state %0d want %h state 3", wlog[wlog.size()-1], slot0_state,
                      {30'h40, 32'hA1A2A3A4, 4'hF});
    end
  endtask

  task automatic test_oversize();
    int w0, i0, p0;
    do_reset();
    w0 = wlog.size(); i0 = irq_cnt; p0 = pops;
    arm(0, 30'h0);
    push_frame(1531, 0, 1'b0);
    drain();
    total++;
    if (slot0_state !== 2'd1 || drop_count !== 16'd1 || irq_cnt != i0 || pops - p0 != 1532) begin
      bad++; $display("FAIL oversize: got state %0d drop %0d irq %0d pops %0d want 1 1 0 1532",
                      slot0_state, drop_count, irq_cnt - i0, pops - p0);
    end
    total++;
    if (wlog.size() - w0 !== 382) begin bad++; $display("FAIL oversize_writes: got %0d want 382", wlog.size() - w0); end
    push_frame(1530, 0, 1'b0);
    drain();
    total++;
    if (slot0_state !== 2'd3 || slot0_count !== 11'd1530 || irq_cnt - i0 != 1) begin
      bad++; $display("FAIL maxframe: got state %0d count %0d irq %0d want 3 1530 1", slot0_state, slot0_count, irq_cnt - i0);
    end
    total++;
    if (wlog[wlog.size()-1] !== {30'd382, 32'hF8F90000, 4'hC}) begin
      bad++; $display("FAIL maxframe_last: got %h want %h", wlog[wlog.size()-1], {30'd382, 32'hF8F90000, 4'hC});
    end
  endtask

  task automatic test_delayed_ack_reset();
    int hold = 0;
    int n = 0;
    int w0;
    do_reset();
    ack_delay = 3;
    arm(0, 30'h10);
    push_frame(4, 1, 1'b0);
    while (!m_stb && n < 50) begin @(negedge sys_clk); n++; end
    total++;
    if (!m_stb) begin bad++; $display("FAIL delay_stb: got m_stb 0 want 1"); end
    while (m_stb && hold < 20) begin
      total++;
      if ({m_adr, m_dat, m_sel, fifo_ack} !== {30'h10, 32'h01020304, 4'hF, 1'b0}) begin
        bad++; $display("FAIL delay_hold: got %h want %h", {m_adr, m_dat, m_sel, fifo_ack},
                        {30'h10, 32'h01020304, 4'hF, 1'b0});
      end
      hold++;
      @(negedge sys_clk);
    end
    total++;
    if (hold !== 4) begin bad++; $display("FAIL delay_cycles: got %0d want 4", hold); end
    drain();
    total++;
    if (slot0_state !== 2'd3 || slot0_count !== 11'd4) begin
      bad++; $display("FAIL delay_commit: got %0d %0d want 3 4", slot0_state, slot0_count);
    end
    // reset in the middle of a held write
    w0 = wlog.size();
    ack_delay = 100;
    arm(1, 30'h20);
    push_frame(4, 5, 1'b0);
    n = 0;
    while (!m_stb && n < 50) begin @(negedge sys_clk); n++; end
    total++;
    if (!m_stb) begin bad++; $display("FAIL rst_stb: got m_stb 0 want 1"); end
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    #1;
    total++;
    if ({m_stb, m_adr, m_dat, m_sel, fifo_ack, rx_irq, drop_count, slot0_state, slot1_state} !== 89'h0) begin
      bad++; $display("FAIL rst_mid: got %h want 0",
                      {m_stb, m_adr, m_dat, m_sel, fifo_ack, rx_irq, drop_count, slot0_state, slot1_state});
    end
    @(negedge sys_clk);
    ack_delay = 0;
    sys_rst_n = 1'b1;
    drain();
    total++;
    if (drop_count !== 16'd1 || wlog.size() != w0) begin
      bad++; $display("FAIL rst_residue: got drop %0d writes %0d want 1 0", drop_count, wlog.size() - w0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_no_slot();
    test_error();
    test_oversize();
    test_delayed_ack_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/minimac_rxctl.md
# minimac_rxctl

Receive controller for the minimac Ethernet MAC. Drains the RX FIFO (byte + EOF/status stream in the sys_clk domain) and packs bytes into 32-bit big-endian words. Writes those words to one of two software-armed receive slots through a simple memory write port, then reports the completed frame length per slot. Frames that arrive with no slot armed, frames with errors and oversized frames are discarded and counted.

## Interface
- MAX_BYTES, 1530: maximum accepted frame length in bytes; longer frames are aborted.
- ADDR_WIDTH, 30: memory word-address width.
- sys_clk  in  1  system clock; only clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  RX FIFO empty; fifo_data/fifo_eof valid whenever 0 (first-word-fall-through).
- fifo_ack  out  1  pops the FIFO head this cycle; asserted only when fifo_empty=0.
- fifo_eof  in  1  head is an end marker; fifo_data[0]=1 means errored frame.
- fifo_data  in  8  head byte.
- slot0_arm, slot1_arm  in  1  one-cycle pulse: load base address, slot becomes ARMED.
- slot0_base, slot1_base  in  ADDR_WIDTH  word address of slot buffer, sampled on arm.
- slot0_clear, slot1_clear  in  1  pulse: DONE slot returns to FREE.
- slot0_state, slot1_state  out  2  FREE=0, ARMED=1, BUSY=2, DONE=3.
- slot0_count, slot1_count  out  11  byte count of the committed frame; valid in DONE.
- m_adr  out  ADDR_WIDTH  write word address.
- m_dat  out  32  write data, first byte in [31:24].
- m_sel  out  4  byte enables, bit 3 = [31:24].
- m_stb  out  1  write request, held until m_ack.
- m_ack  in  1  write accepted this cycle.
- rx_irq  out  1  one-cycle pulse on frame commit.
- drop_count  out  16  saturating count of discarded frames (no slot, error, oversize, empty).

## Operation
- Main FSM states: IDLE, RECV, WRITE, FLUSH, DISCARD.
- IDLE: on a non-empty FIFO head, select the lowest-index ARMED slot, mark it BUSY, clear the byte counter, go to RECV without popping. If no slot is ARMED, go to DISCARD.
- If the IDLE head is an EOF: pop it, increment drop_count and stay IDLE.
- RECV, data head: pop and shift the byte into lane (count mod 4), then increment count.
  - On the fourth byte of a word, go to WRITE with m_sel=4'b1111.
  - If count would exceed MAX_BYTES: pop, return the slot to ARMED, go to DISCARD.
- RECV, EOF head: pop it.
  - Good EOF and count>0: if a partial word is pending, go to FLUSH with m_sel marking filled lanes (e.g. 1 byte gives 4'b1000); otherwise commit.
  - Error EOF or count=0: return the slot to ARMED, increment drop_count, go to IDLE.
- WRITE/FLUSH: drive m_stb with m_adr=base+word index; hold adr/dat/sel stable; no pops. On m_ack, increment the word index. WRITE returns to RECV; FLUSH commits.
- Commit: store count in slotN_count, slot becomes DONE, pulse rx_irq, go to IDLE.
- DISCARD: pop every head until an EOF is popped, then increment drop_count and go to IDLE.
  - Oversize discard counts once.
- Arm acts only on FREE or ARMED slots; clear acts only on DONE slots. Both are ignored otherwise, and an ignored arm does not sample base.
- Arm and slot selection in the same cycle: the arm takes effect next cycle.
- Arm and clear on the same slot in the same cycle: clear wins.

## Timing
- Reset: FSM IDLE, slots FREE, counts 0, bases 0, fifo_ack=0, m_stb=0, m_adr/m_dat/m_sel=0, rx_irq=0, drop_count=0.
- Sustained FIFO throughput: 1 byte/cycle, plus 1 cycle per word write when m_ack returns in the request cycle.
- m_stb rises the cycle after the fourth byte is popped.
- rx_irq asserts the cycle after the final m_ack, or the cycle after the EOF pop when count mod 4 = 0.
- Reset asserted mid-frame aborts immediately with no commit; the FIFO residue is handled as a new frame after reset.
- drop_count saturates at 16'hFFFF.

## Structure
- minimac_pkg holds:
  - FSM state encodings;
  - slot state encodings FREE/ARMED/BUSY/DONE;
  - count width (11).
- Sub-module minimac_rxslot, instantiated twice, holds one slot's state register, base and count, and handles arm/clear/take/release/commit.

## Test plan
- Slot0 armed base 0x100, 6-byte frame 01..06 + good EOF, m_ack immediate -> writes 0x100:01020304 sel F, 0x101:05060000 sel C; slot0_count=6, DONE, one rx_irq.
- Both slots armed, two 4-byte frames back to back -> slot0 then slot1 DONE, counts 4, two rx_irq; second frame has no FLUSH.
- No slot armed, 10-byte frame + EOF -> no m_stb, all 11 entries popped, drop_count=1.
- 5 bytes + error EOF (data=0x01) -> slot0 back to ARMED, drop_count=1, no rx_irq, next frame lands at base again.
- Frame of MAX_BYTES+1 bytes -> DISCARD after byte 1531, slot ARMED, drop_count=1. Separately, a MAX_BYTES frame commits with count 1530.
- m_ack delayed 3 cycles -> m_adr/m_dat/m_sel stable, no fifo_ack while m_stb; sys_rst_n low mid-WRITE -> all outputs reset values next edge.
